// File: rtl/regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug read-out engine on the read side of the CPU register file. A start
// pulse latches an inclusive address range (wrapping at 2^ADDR_W). The engine
// walks that range, drives the register file read address and captures one
// word per step. Each word is offered to a valid/ready sink together with its
// address. With an always-ready sink the engine sustains one word every two
// clocks (READ then SEND).
//
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to enable a running
// modulo-2^DATA_W sum of all accepted words on `checksum`. When the macro is
// undefined, `checksum` is tied to zero and no adder is built.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous, active-high reset (aborts a dump in progress)
//   start         single-cycle dump request, honoured only when idle
//   first_addr    first register of the range, sampled with start
//   last_addr     last register of the range (inclusive), sampled with start
//   rf_read_addr  register file read address (0 outside the READ step)
//   rf_read_data  combinational register file read data
//   out_valid     out_addr/out_data/out_last hold a word
//   out_ready     sink accepts the current word
//   out_addr      register index of the current word
//   out_data      captured register value
//   out_last      current word is the final beat of the dump
//   busy          high whenever the engine is not idle
//   done          one-cycle pulse after the final beat is accepted
//   checksum      running sum of accepted words (0 when feature disabled)
// ----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_end;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic [ADDR_W-1:0] w_rf_read_addr;
    logic              w_accept;

    assign w_accept = r_out_valid & out_ready;

    // Read address is only presented during the single READ step so the
    // register file sees a quiet address (0) the rest of the time.
    always_comb begin
        w_rf_read_addr = {ADDR_W{1'b0}};
        if (r_state == S_READ) begin
            w_rf_read_addr = r_cur;
        end else begin
            w_rf_read_addr = {ADDR_W{1'b0}};
        end
    end

    // Sequencer: range walk, word capture and output channel handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur       <= {ADDR_W{1'b0}};
            r_end       <= {ADDR_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_addr  <= {ADDR_W{1'b0}};
            r_out_data  <= {DATA_W{1'b0}};
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur   <= first_addr;
                        r_end   <= last_addr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_out_data  <= rf_read_data;
                    r_out_addr  <= r_cur;
                    r_out_last  <= (r_cur == r_end);
                    r_out_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    // Word and flags stay frozen until the sink takes them.
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_FIN;
                        end else begin
                            // Natural ADDR_W-bit wrap gives the 31 -> 0 walk.
                            r_cur   <= r_cur + ADDR_ONE;
                            r_state <= S_READ;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of accepted words; cleared when a dump is launched so the
    // value is final from the done pulse until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= {DATA_W{1'b0}};
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= {DATA_W{1'b0}};
        end else if ((r_state == S_SEND) && w_accept) begin
            r_checksum <= r_checksum + r_out_data;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = {DATA_W{1'b0}};
`endif

    assign rf_read_addr = w_rf_read_addr;
    assign out_valid    = r_out_valid;
    assign out_addr     = r_out_addr;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    // Register file model: combinational read, r0 kept at zero.
    logic [31:0] mem [0:31];
    assign rf_read_data = mem[rf_read_addr];

    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .checksum(checksum)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations gathered by the collector
    logic [4:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_done, obs_done_cyc, obs_acc_cyc, obs_stall_bad, obs_stall_seen;
    bit          obs_timeout;
    logic [4:0]  obs_rd_first;
    logic        obs_valid_n1, obs_busy_n1, obs_rst_valid, obs_rst_busy;
    logic [31:0] obs_checksum, obs_checksum_done;

    // Expected values from the reference model
    logic [4:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum;

    // Reference: beats are first, first+1, ... wrapping mod 32, through last.
    task automatic model(input int f, input int l);
        int n;
        exp_addr.delete();
        exp_data.delete();
        exp_sum = 32'd0;
        n = (((l - f) % 32) + 32) % 32 + 1;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(5'((f + i) % 32));
            exp_data.push_back(mem[(f + i) % 32]);
            exp_sum = exp_sum + mem[(f + i) % 32];
        end
`ifndef REGFILE_DUMP_CHECKSUM_EN
        exp_sum = 32'd0;
`endif
    endtask

    // Runs one dump and records what the DUT did (no judging here).
    task automatic collect(input int f, input int l, input int stall_beat, input int stall_len,
                           input int restart_cyc, input int reset_beat, input bit rand_ready);
        logic [4:0]  h_addr;
        logic [31:0] h_data;
        logic        h_last;
        int stall_cnt, beats, rst_state;
        bit finished;
        obs_addr.delete(); obs_data.delete(); obs_last.delete();
        obs_done = 0; obs_done_cyc = -1; obs_acc_cyc = -1; obs_stall_bad = 0; obs_stall_seen = 0;
        obs_rst_valid = 1'bx; obs_rst_busy = 1'bx; obs_checksum_done = 32'hxxxxxxxx;
        h_addr = 5'd0; h_data = 32'd0; h_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; first_addr = f[4:0]; last_addr = l[4:0]; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; first_addr = 5'($urandom); last_addr = 5'($urandom);
        @(negedge clk);
        obs_rd_first = rf_read_addr; obs_valid_n1 = out_valid; obs_busy_n1 = busy;
        beats = 0; stall_cnt = 0; rst_state = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            if (rst_state == 1) rst_state = 2;
            start = (cyc == restart_cyc);
            if (start) begin first_addr = 5'd7; last_addr = 5'd7; end
            if (beats == stall_beat && stall_cnt > 0) begin
                if (out_valid !== 1'b1 || out_addr !== h_addr || out_data !== h_data || out_last !== h_last)
                    obs_stall_bad++;
            end
            if (rst_state == 0 && reset_beat >= 0 && out_valid && beats == reset_beat) begin
                reset = 1'b1; out_ready = 1'b0; rst_state = 1;
            end else if (out_valid && beats == stall_beat && stall_cnt < stall_len) begin
                if (stall_cnt == 0) begin h_addr = out_addr; h_data = out_data; h_last = out_last; end
                out_ready = 1'b0; stall_cnt++; obs_stall_seen++;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            if (rst_state == 2) begin
                obs_rst_valid = out_valid; obs_rst_busy = busy; rst_state = 3;
            end
            if (out_valid && out_ready) begin
                obs_addr.push_back(out_addr); obs_data.push_back(out_data); obs_last.push_back(out_last);
                beats++; obs_acc_cyc = cyc;
            end
            if (done) begin obs_done++; obs_done_cyc = cyc; obs_checksum_done = checksum; end
            if (!busy) begin finished = 1'b1; break; end
        end
        obs_timeout = !finished;
        obs_checksum = checksum;
        start = 1'b0; reset = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; first_addr = 5'd0; last_addr = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({out_valid, out_last, busy, done} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {out_valid, out_last, busy, done}); else n_pass++;
        n_checks++; if (out_addr !== 5'd0) $display("FAIL reset_out_addr got %0d want 0", out_addr); else n_pass++;
        n_checks++; if (out_data !== 32'd0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
        n_checks++; if (rf_read_addr !== 5'd0) $display("FAIL reset_rf_addr got %0d want 0", rf_read_addr); else n_pass++;
        n_checks++; if (checksum !== 32'd0) $display("FAIL reset_checksum got %h want 0", checksum); else n_pass++;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_basic();
        mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
        model(1, 3);
        collect(1, 3, -1, 0, -1, -1, 1'b0);
        n_checks++; if (obs_timeout) $display("FAIL basic_timeout got timeout want finish"); else n_pass++;
        n_checks++; if (obs_rd_first !== 5'd1 || obs_valid_n1 !== 1'b0 || obs_busy_n1 !== 1'b1)
            $display("FAIL basic_latency got addr=%0d valid=%b busy=%b want 1/0/1", obs_rd_first, obs_valid_n1, obs_busy_n1); else n_pass++;
        n_checks++; if (obs_addr.size() != 3) $display("FAIL basic_count got %0d want 3", obs_addr.size()); else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_addr.size() - 1))
                $display("FAIL basic_beat%0d got %0d/%h/%b want %0d/%h/%b", i, obs_addr[i], obs_data[i], obs_last[i],
                         exp_addr[i], exp_data[i], (i == exp_addr.size() - 1));
            else n_pass++;
        end
        n_checks++; if (obs_done != 1 || obs_done_cyc != obs_acc_cyc + 1)
            $display("FAIL basic_done got cnt=%0d cyc=%0d want 1 at %0d", obs_done, obs_done_cyc, obs_acc_cyc + 1); else n_pass++;
        n_checks++; if (obs_checksum_done !== exp_sum || obs_checksum !== exp_sum)
            $display("FAIL basic_checksum got %h/%h want %h", obs_checksum_done, obs_checksum, exp_sum); else n_pass++;
    endtask

    task automatic test_single();
        model(0, 0);
        collect(0, 0, -1, 0, -1, -1, 1'b0);
        n_checks++; if (obs_timeout || obs_addr.size() != 1)
            $display("FAIL single_count got %0d timeout=%b want 1", obs_addr.size(), obs_timeout); else n_pass++;
        if (obs_addr.size() > 0) begin
            n_checks++; if (obs_addr[0] !== 5'd0 || obs_data[0] !== 32'd0 || obs_last[0] !== 1'b1)
                $display("FAIL single_beat got %0d/%h/%b want 0/0/1", obs_addr[0], obs_data[0], obs_last[0]); else n_pass++;
        end
        n_checks++; if (obs_done != 1 || busy !== 1'b0)
            $display("FAIL single_done got done=%0d busy=%b want 1/0", obs_done, busy); else n_pass++;
    endtask

    task automatic test_wrap();
        mem[30] = 32'hA; mem[31] = 32'hB; mem[1] = 32'hC;
        model(30, 1);
        collect(30, 1, -1, 0, -1, -1, 1'b0);
        n_checks++; if (obs_timeout || obs_addr.size() != 4)
            $display("FAIL wrap_count got %0d want 4", obs_addr.size()); else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL wrap_beat%0d got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
        n_checks++; if (obs_checksum !== exp_sum) $display("FAIL wrap_checksum got %h want %h", obs_checksum, exp_sum); else n_pass++;
    endtask

    task automatic test_stall();
        for (int a = 4; a <= 9; a++) mem[a] = $urandom;
        model(4, 9);
        collect(4, 9, 1, 5, -1, -1, 1'b0);
        n_checks++; if (obs_stall_seen != 5 || obs_stall_bad != 0)
            $display("FAIL stall_hold got seen=%0d bad=%0d want 5/0", obs_stall_seen, obs_stall_bad); else n_pass++;
        n_checks++; if (obs_timeout || obs_addr.size() != exp_addr.size())
            $display("FAIL stall_count got %0d want %0d", obs_addr.size(), exp_addr.size()); else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL stall_beat%0d got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        for (int a = 1; a < 32; a++) mem[a] = $urandom;
        model(0, 31);
        collect(0, 31, -1, 0, 5, -1, 1'b0);
        n_checks++; if (obs_timeout || obs_addr.size() != 32 || obs_done != 1)
            $display("FAIL restart_count got beats=%0d done=%0d want 32/1", obs_addr.size(), obs_done); else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL restart_beat%0d got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
        n_checks++; if (obs_checksum !== exp_sum) $display("FAIL restart_checksum got %h want %h", obs_checksum, exp_sum); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
        collect(1, 3, -1, 0, -1, 1, 1'b0);
        n_checks++; if (obs_rst_valid !== 1'b0 || obs_rst_busy !== 1'b0 || obs_done != 0 || obs_addr.size() != 1)
            $display("FAIL midreset got valid=%b busy=%b done=%0d beats=%0d want 0/0/0/1",
                     obs_rst_valid, obs_rst_busy, obs_done, obs_addr.size()); else n_pass++;
        n_checks++; if (obs_checksum !== 32'd0) $display("FAIL midreset_checksum got %h want 0", obs_checksum); else n_pass++;
        model(1, 3);
        collect(1, 3, -1, 0, -1, -1, 1'b0);
        n_checks++; if (obs_timeout || obs_addr.size() != 3 || obs_done != 1)
            $display("FAIL midreset_redump got beats=%0d done=%0d want 3/1", obs_addr.size(), obs_done); else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL midreset_beat%0d got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int f, l;
        for (int it = 0; it < 6; it++) begin
            for (int a = 1; a < 32; a++) mem[a] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            model(f, l);
            collect(f, l, -1, 0, -1, -1, 1'b1);
            n_checks++; if (obs_timeout || obs_addr.size() != exp_addr.size() || obs_done != 1)
                $display("FAIL rand%0d_count got beats=%0d done=%0d want %0d/1 (f=%0d l=%0d)",
                         it, obs_addr.size(), obs_done, exp_addr.size(), f, l); else n_pass++;
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                n_checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_addr.size() - 1))
                    $display("FAIL rand%0d_beat%0d got %0d/%h/%b want %0d/%h", it, i, obs_addr[i], obs_data[i], obs_last[i],
                             exp_addr[i], exp_data[i]);
                else n_pass++;
            end
            n_checks++; if (obs_checksum !== exp_sum)
                $display("FAIL rand%0d_checksum got %h want %h", it, obs_checksum, exp_sum); else n_pass++;
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 32'd0;
        test_reset();
        test_basic();
        test_single();
        test_wrap();
        test_stall();
        test_restart_ignored();
        test_reset_mid_dump();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
